// File: rtl/deserializer_to.sv
// deserializer_to: LSB-first serial-to-parallel receiver with one-cycle word strobe.
// Define DESER_PARITY_EN to receive a trailing even-parity bit per word.
module deserializer_to #(
    parameter int TO    = 16,
    parameter int LOGTO = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          data_i,
    input  logic          valid_i,
    input  logic          sync_i,
    output logic [TO-1:0] data_o,
    output logic          word_valid_o,
    output logic          parity_err_o
);
`ifdef DESER_PARITY_EN
    localparam int FRAME = TO + 1;
`else
    localparam int FRAME = TO;
`endif
    localparam logic [LOGTO:0] LAST = (LOGTO+1)'(FRAME - 1);
    localparam logic [LOGTO:0] TO_C = (LOGTO+1)'(TO);

    // One extra counter bit so the parity slot (index TO) is representable.
    logic [LOGTO:0] r_cnt;
    logic [TO-1:0]  r_shreg;
    logic [LOGTO:0] w_idx;
    logic [LOGTO:0] w_cnt_nxt;
    logic [TO-1:0]  w_shreg;
    logic           w_last;

    assign w_last = valid_i && !sync_i && (r_cnt == LAST);

    always_comb begin
        w_idx   = sync_i ? '0 : r_cnt;
        w_shreg = sync_i ? '0 : r_shreg;
        if (valid_i && w_idx < TO_C) w_shreg[w_idx[LOGTO-1:0]] = data_i;
        w_cnt_nxt = sync_i ? {{LOGTO{1'b0}}, valid_i} :
                    !valid_i ? r_cnt :
                    w_last ? '0 : r_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_shreg      <= '0;
            data_o       <= '0;
            word_valid_o <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_shreg      <= w_shreg;
            word_valid_o <= w_last;
            if (w_last) data_o <= w_shreg;
        end
    end

`ifdef DESER_PARITY_EN
    logic r_par;
    logic w_par;

    assign w_par = (sync_i ? 1'b0 : r_par) ^ (valid_i & data_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_par        <= 1'b0;
            parity_err_o <= 1'b0;
        end else begin
            r_par        <= w_last ? 1'b0 : w_par;
            parity_err_o <= w_last & w_par;
        end
    end
`else
    assign parity_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_deserializer_to.sv
// tb_deserializer_to: table-driven and hand-sequenced checks of deserializer_to with a word scoreboard.
module tb_deserializer_to;
    localparam int TO = 16;
`ifdef DESER_PARITY_EN
    localparam int FRAME = TO + 1;
    localparam bit PAR   = 1'b1;
`else
    localparam int FRAME = TO;
    localparam bit PAR   = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, data_i, valid_i, sync_i;
    logic [TO-1:0] data_o;
    logic          word_valid_o, parity_err_o;

    deserializer_to #(.TO(TO), .LOGTO(4)) dut (
        .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i), .sync_i(sync_i),
        .data_o(data_o), .word_valid_o(word_valid_o), .parity_err_o(parity_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [TO-1:0] d; logic e;} exp_t;
    typedef struct {logic [TO-1:0] w; bit pb; bit e; int gaps;} vec_t;

    exp_t        q[$];
    exp_t        got;
    vec_t        vecs[6];
    int          errors = 0, checks = 0, cyc = 0, nstrobe = 0, t_prev = 0, t_last = 0, n0;
    logic [TO-1:0] last_word = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (word_valid_o) begin
                nstrobe++;
                t_prev = t_last;
                t_last = cyc;
                if (q.size() == 0) chk("unexpected_strobe", 32'd1, 32'd0);
                else begin
                    got = q.pop_front();
                    chk("data_o", 32'(data_o), 32'(got.d));
                    chk("parity_err_o", 32'(parity_err_o), 32'(got.e));
                end
            end else if (parity_err_o !== 1'b0) chk("parity_idle", 32'(parity_err_o), 32'd0);
        end
    end

    task automatic tick(input bit v, input bit d, input bit s);
        valid_i = v;
        data_i  = d;
        sync_i  = s;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        sync_i  = 1'b0;
    endtask

    // Sends bits start..FRAME-1 of a frame; the first bit optionally carries sync_i.
    task automatic send_word(input logic [TO-1:0] w, input bit pb, input bit e, input int gaps,
                             input int start, input bit sync0);
        bit b;
        for (int i = start; i < FRAME; i++) begin
            if (gaps > 0 && i > start)
                repeat ($urandom_range(1, gaps)) begin
                    tick(1'b0, 1'b0, 1'b0);
                    chk("hold_gap", 32'(data_o), 32'(last_word));
                end
            b = (i < TO) ? w[i] : pb;
            if (i == FRAME - 1) q.push_back('{w, PAR & e});
            tick(1'b1, b, sync0 && i == start);
        end
        last_word = w;
    endtask

    task automatic settle(input string name, input int exp_strobes);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk({name, "_strobes"}, 32'(nstrobe - n0), 32'(exp_strobes));
        chk({name, "_pending"}, 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [TO-1:0] w;
        vecs[0] = '{16'hA5C3, 1'b0, 1'b0, 3};
        vecs[1] = '{16'h0001, 1'b1, 1'b0, 0};
        vecs[2] = '{16'h0003, 1'b0, 1'b0, 0};
        vecs[3] = '{16'h0003, 1'b1, 1'b1, 0};
        vecs[4] = '{16'h8E71, 1'b1, 1'b1, 2};
        vecs[5] = '{16'h0000, 1'b1, 1'b1, 1};

        reset = 1'b1; valid_i = 1'b0; sync_i = 1'b0; data_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", 32'(data_o), 32'd0);
        chk("reset_valid", 32'(word_valid_o), 32'd0);
        chk("reset_perr", 32'(parity_err_o), 32'd0);
        reset = 1'b0;

        n0 = nstrobe;
        send_word(16'hA5C3, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("latency", 32'(word_valid_o), 32'd1);
        chk("latency_data", 32'(data_o), 32'hA5C3);
        tick(1'b0, 1'b0, 1'b0);
        chk("strobe_len", 32'(word_valid_o), 32'd0);
        settle("first", 1);

        for (int k = 0; k < 6; k++) begin
            n0 = nstrobe;
            send_word(vecs[k].w, vecs[k].pb, vecs[k].e, vecs[k].gaps, 0, 1'b0);
            settle($sformatf("vec%0d", k), 1);
        end

        n0 = nstrobe;
        send_word(16'hFFFF, 1'b0, 1'b0, 0, 0, 1'b0);
        send_word(16'h0001, 1'b1, 1'b0, 0, 0, 1'b0);
        settle("b2b", 2);
        chk("b2b_spacing", 32'(t_last - t_prev), 32'(FRAME));

        n0 = nstrobe;
        repeat (5) tick(1'b1, 1'($urandom % 2), 1'b0);
        send_word(16'h1234, 1'b1, 1'b0, 0, 0, 1'b1);
        settle("sync", 1);

        n0 = nstrobe;
        w = 16'h5A5A;
        repeat (FRAME - 1) tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, w[0], 1'b1);
        chk("sync_win_valid", 32'(word_valid_o), 32'd0);
        chk("sync_win_data", 32'(data_o), 32'h1234);
        send_word(w, 1'b0, 1'b0, 0, 1, 1'b0);
        settle("sync_win", 1);

        n0 = nstrobe;
        repeat (8) tick(1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midreset_data", 32'(data_o), 32'd0);
        chk("midreset_valid", 32'(word_valid_o), 32'd0);
        chk("midreset_perr", 32'(parity_err_o), 32'd0);
        last_word = '0;
        send_word(16'h00F0, 1'b0, 1'b0, 0, 0, 1'b0);
        settle("after_reset", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
